// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory access controller.
//   - request op encodings (op_e)
//   - controller FSM state encoding (state_e)
//   - default geometry of the attached 128x24 memory
//   - CS polarity constants for the memory port
//   - small helpers that classify an op
package mem_access_pkg;

  localparam int ADDR_W_DEFAULT    = 8;
  localparam int DATA_W_DEFAULT    = 24;
  localparam int MEM_DEPTH_DEFAULT = 128;

  localparam logic CS_READ  = 1'b0;
  localparam logic CS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    OP_READ      = 2'b00,
    OP_WRITE     = 2'b01,
    OP_READ_IND  = 2'b10,
    OP_WRITE_IND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE_PTR = 3'd1,
    ST_CAPT_PTR  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_CAPT      = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  function automatic logic op_is_write(input op_e op);
    return (op == OP_WRITE) || (op == OP_WRITE_IND);
  endfunction

  function automatic logic op_is_ind(input op_e op);
    return (op == OP_READ_IND) || (op == OP_WRITE_IND);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: WIDTH-bit event counter that sticks at all-ones.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset, clears the count
//   inc_i    count one event this cycle
//   count_o  current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator for the synchronous 128x24 memory. Accepts one
// request at a time (direct or pointer-indirect read/write), sequences the
// memory cycles and returns a single response.
//
// Optional build macro: MEM_ACCESS_STATS_EN adds rd_count_o / wr_count_o,
// saturating counts of issued read / write memory cycles.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake (ready only in IDLE)
//   req_op_i               00 READ, 01 WRITE, 10 READ_IND, 11 WRITE_IND
//   req_addr_i, req_wdata_i  address M and write data
//   rsp_valid_o/ready_i    response handshake, response held while stalled
//   rsp_rdata_o, rsp_err_o read data (0 for writes/errors), illegal-address flag
//   mem_mar_o, mem_wdata_o, mem_en_o, mem_cs_o  registered memory drive
//   mem_rdata_i            memory data_out
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request, req_ready high
// ISSUE_PTR | read cycle on M to fetch the pointer
// CAPT_PTR  | pointer data on mem_rdata, range-checked
// ISSUE     | memory cycle on the target address
// CAPT      | read data on mem_rdata, captured into the response
// RESP      | response presented until rsp_ready
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_mar_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_en_o,
  output logic              mem_cs_o
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       rd_count_o,
  output logic [15:0]       wr_count_o
`endif
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  op_e               req_op;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] mem_mar_q, mem_mar_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_cs_q, mem_cs_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < MEM_DEPTH;
  endfunction

  assign req_op = op_e'(req_op_i);
  // Upper bits of the pointer word are ignored.
  assign ptr    = mem_rdata_i[ADDR_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (!addr_ok(req_addr_i)) begin
            state_d = ST_RESP;
          end else if (op_is_ind(req_op)) begin
            state_d = ST_ISSUE_PTR;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE_PTR: state_d = ST_CAPT_PTR;
      ST_CAPT_PTR:  state_d = addr_ok(ptr) ? ST_ISSUE : ST_RESP;
      ST_ISSUE:     state_d = op_is_write(op_q) ? ST_RESP : ST_CAPT;
      ST_CAPT:      state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs are registered, so they are derived from state_d:
  // mem_en is high exactly during ISSUE / ISSUE_PTR cycles.
  always_comb begin
    op_d        = op_q;
    mem_mar_d   = mem_mar_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_en_d    = (state_d == ST_ISSUE) || (state_d == ST_ISSUE_PTR);
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d        = req_op;
          mem_wdata_d = req_wdata_i;
          rsp_rdata_d = '0;
          rsp_err_d   = !addr_ok(req_addr_i);
          if (addr_ok(req_addr_i)) begin
            mem_mar_d = req_addr_i;
          end
        end
      end
      ST_CAPT_PTR: begin
        if (addr_ok(ptr)) begin
          mem_mar_d = ptr;
        end else begin
          rsp_err_d = 1'b1;
        end
      end
      ST_CAPT:     rsp_rdata_d = mem_rdata_i;
      default:     ;
    endcase
    mem_cs_d = ((state_d == ST_ISSUE) && op_is_write(op_d)) ? CS_WRITE : CS_READ;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q        <= OP_READ;
      mem_mar_q   <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_cs_q    <= CS_READ;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      op_q        <= op_d;
      mem_mar_q   <= mem_mar_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_cs_q    <= mem_cs_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_mar_o   = mem_mar_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_cs_o    = mem_cs_q;

`ifdef MEM_ACCESS_STATS_EN
  // Every mem_en cycle is an ISSUE or ISSUE_PTR cycle; pointer fetches are reads.
  sat_counter #(.WIDTH(16)) u_rd_count (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (mem_en_q && (mem_cs_q == CS_READ)),
    .count_o (rd_count_o)
  );

  sat_counter #(.WIDTH(16)) u_wr_count (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (mem_en_q && (mem_cs_q == CS_WRITE)),
    .count_o (wr_count_o)
  );
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 128x24 synchronous
// memory, a response scoreboard queue and a memory-pulse monitor.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  typedef struct packed {
    logic        cs;
    logic [7:0]  mar;
    logic [23:0] wd;
  } pulse_t;

  typedef struct {
    logic [23:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_addr = 8'd0;
  logic [23:0] req_wdata = 24'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [23:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mem_mar;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = 24'd0;
  logic        mem_en;
  logic        mem_cs;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int checks = 0;
  int failures = 0;
  int adj_viol = 0;
  int bad_en = 0;
  logic prev_en = 1'b0;

  exp_t   sb[$];
  pulse_t pq[$];

  logic [23:0] mem [128];
  logic        mem_init_done = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_mar_o   (mem_mar),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_en_o    (mem_en),
    .mem_cs_o    (mem_cs)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .rd_count_o  (rd_count),
    .wr_count_o  (wr_count)
`endif
  );

  // Synchronous memory: samples EN/CS/MAR at posedge, read data valid next cycle.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem[30] <= 24'h000005;
      mem[40] <= 24'h00001E;
      mem[41] <= 24'h0000C8;
      mem[42] <= 24'hABCD1E;
      mem_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_cs) mem[mem_mar[6:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_mar[6:0]];
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_en) begin
      pq.push_back({mem_cs, mem_mar, mem_wdata});
      if (prev_en) adj_viol++;
      if (req_ready || rsp_valid) bad_en++;
    end
    prev_en = rst_n && mem_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic pulse_t mkp(input logic cs, input logic [7:0] mar, input logic [23:0] wd);
    pulse_t p;
    p.cs  = cs;
    p.mar = mar;
    p.wd  = wd;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input pulse_t got, input pulse_t exp);
    chk({tag, "_cs"}, 32'(got.cs), 32'(exp.cs));
    chk({tag, "_mar"}, 32'(got.mar), 32'(exp.mar));
    if (exp.cs) chk({tag, "_wdata"}, 32'(got.wd), 32'(exp.wd));
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] addr,
                        input logic [23:0] wd, input logic [23:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int stall, input bit ghost,
                        input int np, input pulse_t e0, input pulse_t e1);
    exp_t e;
    int   lat;
    sb.push_back('{exp_rd, exp_err, exp_lat});
    pq.delete();
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
    chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (ghost) begin
        req_valid = 1'b1;
        req_op    = OP_WRITE;
        req_addr  = addr;
        req_wdata = 24'h0000AA;
      end
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_stall_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
      chk({tag, "_stall_err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, "_npulses"}, 32'(pq.size()), 32'(np));
    if (np >= 1 && pq.size() >= 1) chk_pulse({tag, "_p0"}, pq[0], e0);
    if (np >= 2 && pq.size() >= 2) chk_pulse({tag, "_p1"}, pq[1], e1);
  endtask

  initial begin
    pulse_t np0;
    np0 = mkp(1'b0, 8'd0, 24'd0);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_mar", 32'(mem_mar), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    do_req("rd30", OP_READ, 8'd30, 24'd0, 24'h000005, 1'b0, 3, 0, 1'b0, 1, mkp(1'b0, 8'd30, 24'd0), np0);
    do_req("wr31", OP_WRITE, 8'd31, 24'h000009, 24'd0, 1'b0, 2, 0, 1'b0, 1, mkp(1'b1, 8'd31, 24'h000009), np0);
    do_req("rd31", OP_READ, 8'd31, 24'd0, 24'h000009, 1'b0, 3, 0, 1'b0, 1, mkp(1'b0, 8'd31, 24'd0), np0);
    do_req("rdind40", OP_READ_IND, 8'd40, 24'd0, 24'h000005, 1'b0, 5, 0, 1'b0, 2,
           mkp(1'b0, 8'd40, 24'd0), mkp(1'b0, 8'd30, 24'd0));
    do_req("rd200", OP_READ, 8'd200, 24'd0, 24'd0, 1'b1, 1, 0, 1'b0, 0, np0, np0);
    do_req("wrind41", OP_WRITE_IND, 8'd41, 24'h000123, 24'd0, 1'b1, 3, 0, 1'b0, 1, mkp(1'b0, 8'd41, 24'd0), np0);
    do_req("wr127", OP_WRITE, 8'd127, 24'h000055, 24'd0, 1'b0, 2, 0, 1'b0, 1, mkp(1'b1, 8'd127, 24'h000055), np0);
    do_req("rd127", OP_READ, 8'd127, 24'd0, 24'h000055, 1'b0, 3, 0, 1'b0, 1, mkp(1'b0, 8'd127, 24'd0), np0);
    do_req("rd128", OP_READ, 8'd128, 24'd0, 24'd0, 1'b1, 1, 0, 1'b0, 0, np0, np0);
    do_req("wrind40", OP_WRITE_IND, 8'd40, 24'h000007, 24'd0, 1'b0, 4, 0, 1'b0, 2,
           mkp(1'b0, 8'd40, 24'd0), mkp(1'b1, 8'd30, 24'h000007));
    do_req("rdind42", OP_READ_IND, 8'd42, 24'd0, 24'h000007, 1'b0, 5, 0, 1'b0, 2,
           mkp(1'b0, 8'd42, 24'd0), mkp(1'b0, 8'd30, 24'd0));
    do_req("stall31", OP_READ, 8'd31, 24'd0, 24'h000009, 1'b0, 3, 4, 1'b1, 1, mkp(1'b0, 8'd31, 24'd0), np0);
    do_req("rd31_after_ghost", OP_READ, 8'd31, 24'd0, 24'h000009, 1'b0, 3, 0, 1'b0, 1, mkp(1'b0, 8'd31, 24'd0), np0);

    // Reset asserted in the middle of a READ's ISSUE cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_READ;
    req_addr  = 8'd30;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("midrst_en_before", 32'(mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en_now", 32'(mem_en), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pq.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_pulse", 32'(pq.size()), 32'd0);
    chk("midrst_idle_ready", 32'(req_ready), 32'd1);
    chk("midrst_idle_valid", 32'(rsp_valid), 32'd0);

    do_req("post_rdind40", OP_READ_IND, 8'd40, 24'd0, 24'h000007, 1'b0, 5, 0, 1'b0, 2,
           mkp(1'b0, 8'd40, 24'd0), mkp(1'b0, 8'd30, 24'd0));
    do_req("post_wr31", OP_WRITE, 8'd31, 24'h000077, 24'd0, 1'b0, 2, 0, 1'b0, 1, mkp(1'b1, 8'd31, 24'h000077), np0);
`ifdef MEM_ACCESS_STATS_EN
    chk("stats_rd_count", 32'(rd_count), 32'd2);
    chk("stats_wr_count", 32'(wr_count), 32'd1);
`endif
    do_req("post_rd31", OP_READ, 8'd31, 24'd0, 24'h000077, 1'b0, 3, 0, 1'b0, 1, mkp(1'b0, 8'd31, 24'd0), np0);

    chk("adjacent_en_pulses", 32'(adj_viol), 32'd0);
    chk("en_in_idle_or_resp", 32'(bad_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
